// File: rtl/fir_mac_8bit.sv
// fir_mac_8bit: sequential multiply-accumulate FIR stage that fetches one weight per cycle from the weight memory.
// Optional macro FIR_MAC_SAT_EN makes the accumulator saturate instead of wrapping.
module fir_mac_8bit #(
    parameter int TAPS = 8,
    parameter int DW   = 8,
    parameter int AW   = 3,
    parameter int ACCW = 19
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic signed [DW-1:0]   x_in,
    output logic                   w_rd,
    output logic [AW-1:0]          w_addr,
    input  logic signed [DW-1:0]   w_q,
    output logic signed [ACCW-1:0] y,
    output logic                   done,
    output logic                   busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]             r_state;
    logic [AW-1:0]          r_idx;
    logic [AW-1:0]          r_addrD;
    logic signed [DW-1:0]   r_tap [TAPS];
    logic signed [ACCW-1:0] r_acc;
    logic signed [ACCW-1:0] r_y;
    logic                   r_done;

    logic signed [DW-1:0]   w_tapSel;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prodExt;
    logic signed [ACCW-1:0] w_sum;

    // w_q always answers the address issued one cycle earlier, so pair it with the delayed address.
    assign w_tapSel  = (r_state == S_DRAIN) ? r_tap[TAPS-1] : r_tap[r_addrD];
    assign w_prod    = w_tapSel * w_q;
    assign w_prodExt = ACCW'(w_prod);

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

    logic signed [ACCW:0] w_sumWide;

    assign w_sumWide = (ACCW+1)'(r_acc) + (ACCW+1)'(w_prodExt);

    // One guard bit is enough: a disagreeing top pair means the add left the ACCW range.
    always_comb begin
        w_sum = w_sumWide[ACCW-1:0];
        if (w_sumWide[ACCW] != w_sumWide[ACCW-1]) begin
            w_sum = w_sumWide[ACCW] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign w_sum = r_acc + w_prodExt;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_addrD <= '0;
            r_acc   <= '0;
            r_y     <= '0;
            r_done  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_tap[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_tap[0] <= x_in;
                        for (int k = 1; k < TAPS; k++) begin
                            r_tap[k] <= r_tap[k-1];
                        end
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_idx   <= r_idx + AW'(1);
                    r_addrD <= r_idx;
                    // The first RUN edge has no weight back from memory yet.
                    if (r_idx != '0) begin
                        r_acc <= w_sum;
                    end
                    if (r_idx == AW'(TAPS-1)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_y     <= w_sum;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_rd   = (r_state == S_RUN);
    assign w_addr = r_idx;
    assign y      = r_y;
    assign done   = r_done;
    assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_mac_8bit.sv
// Bench for fir_mac_8bit: table vectors, multi-cycle corner sequences and randomized samples against a reference model.
// A second instance with ACCW=16 exercises wrap (or saturation when FIR_MAC_SAT_EN is defined).
module tb_fir_mac_8bit;

    localparam int TAPS = 8;

    typedef struct {
        logic signed [7:0] x;
        int                wSet;
        int                expY;
    } vec_t;

    logic              clock  = 1'b0;
    logic              reset  = 1'b0;
    logic              enable = 1'b0;
    logic signed [7:0] x_in   = '0;
    logic signed [7:0] w_q    = '0;
    logic              w_rd, w_rd16;
    logic [2:0]        w_addr, w_addr16;
    logic signed [18:0] y;
    logic signed [15:0] y16;
    logic              done, done16;
    logic              busy, busy16;

    int checks   = 0;
    int failures = 0;
    int lastY    = 0;
    int lastY16  = 0;

    logic signed [7:0] weights [TAPS];
    int                modelTaps [TAPS];
    vec_t              tbl [24];
    logic              rdLat   = 1'b0;
    logic [2:0]        addrLat = '0;

    always #5 clock = ~clock;

    fir_mac_8bit dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .x_in   (x_in),
        .w_rd   (w_rd),
        .w_addr (w_addr),
        .w_q    (w_q),
        .y      (y),
        .done   (done),
        .busy   (busy)
    );

    fir_mac_8bit #(.ACCW(16)) dut16 (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .x_in   (x_in),
        .w_rd   (w_rd16),
        .w_addr (w_addr16),
        .w_q    (w_q),
        .y      (y16),
        .done   (done16),
        .busy   (busy16)
    );

    // Weight memory model: one-cycle read latency, garbage on cycles with no read.
    always @(negedge clock) begin
        rdLat   = w_rd;
        addrLat = w_addr;
    end

    always @(posedge clock) begin
        #1;
        w_q = rdLat ? weights[addrLat] : 8'($urandom);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: y = sum of tap[k]*weight[k], accumulated in address order.
    function automatic int modelY(input bit narrow);
        int acc;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            acc += modelTaps[k] * int'(weights[k]);
            if (narrow) begin
`ifdef FIR_MAC_SAT_EN
                if (acc > 32767) acc = 32767;
                else if (acc < -32768) acc = -32768;
`else
                acc = int'(shortint'(acc));
`endif
            end
        end
        return acc;
    endfunction

    task automatic modelPush(input logic signed [7:0] x);
        for (int k = TAPS-1; k >= 1; k--) begin
            modelTaps[k] = modelTaps[k-1];
        end
        modelTaps[0] = int'(x);
    endtask

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic loadWeights(input int set);
        for (int k = 0; k < TAPS; k++) begin
            case (set)
                0:       weights[k] = 8'(k + 1);
                1:       weights[k] = 8'h7F;
                2:       weights[k] = 8'h80;
                default: weights[k] = 8'($urandom);
            endcase
        end
    endtask

    task automatic doReset();
        enable = 1'b0;
        reset  = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        for (int k = 0; k < TAPS; k++) modelTaps[k] = 0;
        lastY   = 0;
        lastY16 = 0;
    endtask

    // Idle for gap cycles, then present one sample and follow it to its done pulse.
    task automatic applyStimulus(input logic signed [7:0] x, input int gap, input string tag);
        int cyc;
        int busyCnt;
        bit seen;
        for (int g = 0; g < gap; g++) begin
            @(posedge clock); #1;
            if (g == 0) begin
                checkOutput({tag, " idle done low"}, done, 0);
                checkOutput({tag, " idle busy low"}, busy, 0);
                checkOutput({tag, " y held"}, y, lastY);
            end
        end
        enable = 1'b1;
        x_in   = x;
        @(posedge clock); #1;
        enable = 1'b0;
        modelPush(x);
        checkOutput({tag, " done low after accept"}, done, 0);
        busyCnt = busy ? 1 : 0;
        seen    = 1'b0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clock); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busyCnt++;
        end
        checkOutput({tag, " done seen"}, seen, 1);
        checkOutput({tag, " latency"}, cyc, 9);
        checkOutput({tag, " busy cycles"}, busyCnt, 9);
        checkOutput({tag, " busy low at done"}, busy, 0);
        lastY   = modelY(1'b0);
        lastY16 = modelY(1'b1);
        checkOutput({tag, " y"}, y, lastY);
        checkOutput({tag, " y16"}, y16, lastY16);
    endtask

    initial begin
        int curSet;
        int dones;
        int doneCyc;
        int yAtDone;

        for (int i = 0; i < 8; i++) begin
            tbl[i].x         = (i == 0) ? 8'sd1 : 8'sd0;
            tbl[i].wSet      = 0;
            tbl[i].expY      = i + 1;
            tbl[8+i].x       = 8'h7F;
            tbl[8+i].wSet    = 1;
            tbl[8+i].expY    = 16129 * (i + 1);
            tbl[16+i].x      = 8'h80;
            tbl[16+i].wSet   = 2;
            tbl[16+i].expY   = 16384 * (i + 1);
        end

        loadWeights(0);
        for (int k = 0; k < TAPS; k++) modelTaps[k] = 0;

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset y", y, 0);
        checkOutput("reset y16", y16, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset w_rd", w_rd, 0);
        checkOutput("reset w_addr", w_addr, 0);
        reset = 1'b1;

        curSet = -1;
        for (int i = 0; i < 24; i++) begin
            if (tbl[i].wSet != curSet) begin
                curSet = tbl[i].wSet;
                loadWeights(curSet);
                doReset();
            end
            applyStimulus(tbl[i].x, 2, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d table y", i), y, tbl[i].expY);
        end

        // Enable pulse while busy must be dropped.
        loadWeights(0);
        doReset();
        applyStimulus(8'sd3, 1, "pre-ignore");
        @(posedge clock); #1;
        enable = 1'b1;
        x_in   = 8'sd7;
        @(posedge clock); #1;
        enable = 1'b0;
        modelPush(8'sd7);
        dones   = 0;
        doneCyc = 0;
        yAtDone = 0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clock); #1;
            if (done) begin
                dones++;
                doneCyc = c;
                yAtDone = int'(y);
            end
            if (c == 3) begin
                enable = 1'b1;
                x_in   = 8'sd5;
            end
            if (c == 4) enable = 1'b0;
        end
        lastY   = modelY(1'b0);
        lastY16 = modelY(1'b1);
        checkOutput("busy-enable done count", dones, 1);
        checkOutput("busy-enable latency", doneCyc, 9);
        checkOutput("busy-enable y", yAtDone, lastY);
        applyStimulus(8'sd0, 2, "after-ignore");

        // Reset in the middle of RUN aborts the computation.
        loadWeights(0);
        doReset();
        applyStimulus(8'sd4, 1, "pre-abort");
        @(posedge clock); #1;
        enable = 1'b1;
        x_in   = 8'sd9;
        @(posedge clock); #1;
        enable = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checkOutput("abort done", done, 0);
        checkOutput("abort y", y, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort w_rd", w_rd, 0);
        @(posedge clock); #1;
        checkOutput("abort done stays low", done, 0);
        reset = 1'b1;
        for (int k = 0; k < TAPS; k++) modelTaps[k] = 0;
        lastY   = 0;
        lastY16 = 0;
        loadWeights(3);
        weights[0] = 8'sd3;
        applyStimulus(8'sd1, 1, "post-abort");
        checkOutput("post-abort y is 3", y, 3);

        // Back-to-back: enable during the done cycle.
        loadWeights(0);
        doReset();
        applyStimulus(8'sd10, 1, "b2b first");
        applyStimulus(-8'sd20, 0, "b2b second");
        applyStimulus(8'sd30, 0, "b2b third");

        // Randomized samples and gaps.
        for (int blk = 0; blk < 2; blk++) begin
            loadWeights(3);
            if (blk == 1) begin
                weights[0] = 8'h80;
                weights[7] = 8'h7F;
            end
            doReset();
            for (int n = 0; n < 15; n++) begin
                applyStimulus(8'($urandom), int'($urandom_range(0, 3)), $sformatf("rand%0d_%0d", blk, n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
